sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requesting masters (2..8).
REQ-002 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-003 Parameter DATA_W, default 16, SRAM data width (fixed 2 byte lanes).
REQ-004 Parameter WAIT_CYCLES, default 1, ACCESS-state length in clocks (1..15).
REQ-005 Clk  in  1  sole clock, all state on rising edge.
REQ-006 Reset_n  in  1  reset, asynchronous, active-low.
REQ-007 req  in  NUM_PORTS  per-port access request, held until ack.
REQ-008 we  in  NUM_PORTS  per-port 1=write, 0=read.
REQ-009 addr  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W].
REQ-010 wdata  in  NUM_PORTS*DATA_W  per-port write data.
REQ-011 be_n  in  NUM_PORTS*2  per-port byte enables, active-low, bit0=low byte.
REQ-012 ack  out  NUM_PORTS  one-cycle completion pulse to the served port.
REQ-013 rdata  out  DATA_W  read data, shared by all ports.
REQ-014 rvalid  out  1  one-cycle pulse, rdata valid for a completed read.
REQ-015 SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  ADDR_W/1/1/1/1/1  SRAM pins.
REQ-016 SRAM_DQ  inout  DATA_W  SRAM data bus.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS, DONE; IDLE->SETUP when any req high; SETUP->ACCESS; ACCESS->DONE after WAIT_CYCLES clocks; DONE->IDLE always.
REQ-018 In IDLE, winner shall be chosen per REQ-033/034; winner index, we, addr, wdata, be_n shall be registered at that edge; later input changes shall be ignored until DONE.
REQ-019 SRAM_ADDR, SRAM_LB_N, SRAM_UB_N shall come from the latched values throughout SETUP, ACCESS and DONE.
REQ-020 SRAM_CE_N low in SETUP, ACCESS and DONE; high in IDLE.
REQ-021 Read: SRAM_OE_N low in SETUP and ACCESS; high in DONE and IDLE; SRAM_WE_N high.
REQ-022 Write: SRAM_WE_N low only in ACCESS; SRAM_OE_N high; SRAM_DQ driven with latched wdata in SETUP, ACCESS and DONE.
REQ-023 SRAM_DQ shall be high-Z in every state except those in REQ-022; never driven while SRAM_OE_N low.
REQ-024 Read data: SRAM_DQ registered into rdata at the edge leaving the last ACCESS cycle; rdata holds until the next read.
REQ-025 ack[winner] high for exactly the DONE cycle; rvalid high in DONE for reads only.
REQ-026 Latency: request sampled in IDLE at cycle 0 -> ack at cycle WAIT_CYCLES+2; back-to-back period WAIT_CYCLES+3.
REQ-027 Requester shall deassert or change req on the edge after seeing ack; req high in the following IDLE is a new request.
REQ-028 No req in IDLE: FSM stays in IDLE, all SRAM strobes high, DQ high-Z.
REQ-029 Requests arriving during SETUP/ACCESS/DONE are held pending and arbitrated in the next IDLE.

Reset
REQ-030 Reset_n low shall, asynchronously and from any state including mid-write: FSM=IDLE, SRAM_CE_N/OE_N/WE_N/LB_N/UB_N=1, SRAM_ADDR=0, SRAM_DQ high-Z, ack=0, rvalid=0, rdata=0, round-robin pointer=0.
REQ-031 An access interrupted by reset shall not be acked after reset release.
REQ-032 First arbitration is possible in the first IDLE cycle after Reset_n rises.

Configuration
REQ-033 With SRAM_ARB_RR_EN defined: round-robin; search starts at (last winner+1) mod NUM_PORTS; pointer updates in DONE.
REQ-034 Without SRAM_ARB_RR_EN: fixed priority, lowest-index requesting port wins; no pointer register.

Verification
REQ-035 WAIT_CYCLES=1, port0 write addr 0x00123 data 0xBEEF be_n=00 -> WE_N low 1 cycle in ACCESS, ack[0] at cycle 3, SRAM model holds 0xBEEF.
REQ-036 Port1 read addr 0x00123 after REQ-035 -> OE_N low 2 cycles, rvalid+ack[1] at cycle 3, rdata=0xBEEF, DQ never driven by DUT.
REQ-037 Port0 write be_n=10 data 0x1234 over 0xBEEF -> read back 0xBE34.
REQ-038 Both ports request continuously, RR_EN defined -> grants 0,1,0,1; undefined -> grants 0,0,0.
REQ-039 Reset_n pulsed low during ACCESS of a write -> WE_N/CE_N high and DQ high-Z same cycle, no ack after release.
REQ-040 WAIT_CYCLES=3 read -> ack at cycle 5, next grant IDLE at cycle 6.

Source files
------------

// File: rtl/sram_arbiter.sv
// Multi-port arbiter in front of one asynchronous 16-bit SRAM; one access at a time via IDLE/SETUP/ACCESS/DONE.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest port index wins).
module sram_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  input  logic [NUM_PORTS*2-1:0]      be_n,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        rvalid,
  output logic [ADDR_W-1:0]           SRAM_ADDR,
  output logic                        SRAM_CE_N,
  output logic                        SRAM_OE_N,
  output logic                        SRAM_WE_N,
  output logic                        SRAM_LB_N,
  output logic                        SRAM_UB_N,
  inout  wire  [DATA_W-1:0]           SRAM_DQ
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   wait_cnt_reg;
  logic [IDX_W-1:0]   sel_reg;
  logic [IDX_W-1:0]   win_idx;
  logic               we_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [1:0]         be_n_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic               last_access;
  logic               dq_drive;

  assign last_access = (wait_cnt_reg == CNT_W'(WAIT_CYCLES - 1));

`ifdef SRAM_ARB_RR_EN
  logic [IDX_W-1:0] ptr_reg;

  // Search starts at the port after the previous winner.
  always_comb begin
    logic found;
    found   = 1'b0;
    win_idx = ptr_reg;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int idx;
      idx = (int'(ptr_reg) + k) % NUM_PORTS;
      if (!found && req[idx]) begin
        win_idx = IDX_W'(idx);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_reg <= '0;
    end else if (state_reg == DONE) begin
      ptr_reg <= (sel_reg == IDX_W'(NUM_PORTS - 1)) ? '0 : sel_reg + 1'b1;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req[k]) win_idx = IDX_W'(k);
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      sel_reg      <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      be_n_reg     <= 2'b11;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      // The winning request is frozen here; input changes are ignored until DONE.
      if (state_reg == IDLE && |req) begin
        sel_reg   <= win_idx;
        we_reg    <= we[win_idx];
        addr_reg  <= addr[int'(win_idx)*ADDR_W +: ADDR_W];
        wdata_reg <= wdata[int'(win_idx)*DATA_W +: DATA_W];
        be_n_reg  <= be_n[int'(win_idx)*2 +: 2];
      end
      if (state_reg == ACCESS) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else                     wait_cnt_reg <= '0;
      if (state_reg == ACCESS && last_access && !we_reg) rdata_reg <= SRAM_DQ;
    end
  end

  always_comb begin
    state_next = state_reg;
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_LB_N  = 1'b1;
    SRAM_UB_N  = 1'b1;
    dq_drive   = 1'b0;
    rvalid     = 1'b0;
    case (state_reg)
      IDLE:   if (|req) state_next = SETUP;
      SETUP:  state_next = ACCESS;
      ACCESS: if (last_access) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_reg != IDLE) begin
      SRAM_CE_N = 1'b0;
      SRAM_LB_N = be_n_reg[0];
      SRAM_UB_N = be_n_reg[1];
      dq_drive  = we_reg;
      SRAM_OE_N = !(!we_reg && (state_reg == SETUP || state_reg == ACCESS));
      SRAM_WE_N = !(we_reg && state_reg == ACCESS);
      rvalid    = (state_reg == DONE) && !we_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ack
      assign ack[gi] = (state_reg == DONE) && (sel_reg == IDX_W'(gi));
    end
  endgenerate

  assign SRAM_ADDR = addr_reg;
  assign rdata     = rdata_reg;
  assign SRAM_DQ   = dq_drive ? wdata_reg : {DATA_W{1'bz}};

endmodule
